// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data RAM between the CPU MEM stage and a DMA master
// Ports: clk/reset; cpu_* request/stall/read-return; dma_* request/grant/read-return;
// addr_err sticky out-of-range flag; mem_* drive the 1-cycle-latency word-addressed RAM.
module dm_arbiter #(
  parameter int ADDR_W = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_be,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [31:0]       dma_addr,
  input  logic [31:0]       dma_wdata,
  input  logic [3:0]        dma_be,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [31:0]       dma_rdata,
  output logic              addr_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [1:0] {NONE, OWN_C, OWN_D} own_t;
  own_t        rd_owner;
  logic [3:0]  wait_cnt;
  logic [31:0] cpu_hold, dma_hold, addr;
  logic        force_d, win_c, win_d, we, unused_lsb;
  assign force_d = dma_req && wait_cnt == 4'(MAX_WAIT);
  // Grants are gated by reset so the RAM sees no strobe while reset is held.
  assign win_d = !reset && (force_d || (dma_req && !cpu_req));
  assign win_c = !reset && !force_d && cpu_req;
  assign mem_en = win_c || win_d;
  assign dma_gnt = win_d;
  assign cpu_stall = cpu_req && !win_c;
  assign addr = win_d ? dma_addr : cpu_addr;
  assign we = win_d ? dma_we : cpu_we;
  assign mem_addr = addr[ADDR_W+1:2];
  assign mem_wdata = win_d ? dma_wdata : cpu_wdata;
  assign mem_we = (mem_en && we) ? (win_d ? dma_be : cpu_be) : 4'b0000;
  assign unused_lsb = ^addr[1:0];
  // Read data comes straight from the RAM output in the return cycle; otherwise the last value is held.
  assign cpu_rvalid = rd_owner == OWN_C;
  assign dma_rvalid = rd_owner == OWN_D;
  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_hold;
  assign dma_rdata = dma_rvalid ? mem_rdata : dma_hold;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      rd_owner <= NONE;
      cpu_hold <= '0;
      dma_hold <= '0;
      addr_err <= 1'b0;
    end else begin
      wait_cnt <= (!dma_req || win_d) ? 4'd0 : (wait_cnt == 4'(MAX_WAIT) ? wait_cnt : wait_cnt + 4'd1);
      rd_owner <= (mem_en && !we) ? (win_d ? OWN_D : OWN_C) : NONE;
      if (cpu_rvalid) cpu_hold <= mem_rdata;
      if (dma_rvalid) dma_hold <= mem_rdata;
      if (mem_en && |addr[31:ADDR_W+2]) addr_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: table-driven check of dm_arbiter against a 1-cycle-latency RAM model
module tb_dm_arbiter;
  typedef struct packed {
    logic cr, cw; logic [31:0] ca, cd; logic [3:0] cb;
    logic dr, dw; logic [31:0] da, dd; logic [3:0] db;
  } in_t;
  typedef struct packed {
    logic stall, gnt, en; logic [3:0] we; logic [9:0] ma; logic [31:0] md;
    logic crv; logic [31:0] crd; logic drv; logic [31:0] drd; logic aerr;
  } ex_t;
  logic clk = 0, reset = 1;
  logic cpu_req, cpu_we, dma_req, dma_we, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, addr_err, mem_en;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic [3:0] cpu_be, dma_be, mem_we;
  logic [9:0] mem_addr;
  logic [31:0] ram [1024];
  int nvec = 0, nbad = 0;
  in_t vin [20];
  ex_t vex [20];
  always #5 clk = ~clk;
  dm_arbiter #(.ADDR_W(10), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_be(dma_be),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .addr_err(addr_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'hA000_0000 | i;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++) if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      if (mem_we == 4'b0) mem_rdata <= ram[mem_addr];
    end
  end
  function automatic in_t idle();
    return '{0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0};
  endfunction
  function automatic in_t cpu(logic w, logic [31:0] a, logic [31:0] d, logic [3:0] b);
    return '{1'b1, w, a, d, b, 0, 0, 32'h0, 32'h0, 4'h0};
  endfunction
  function automatic in_t dma(logic w, logic [31:0] a, logic [31:0] d, logic [3:0] b);
    return '{0, 0, 32'h0, 32'h0, 4'h0, 1'b1, w, a, d, b};
  endfunction
  task automatic drive(in_t v);
    {cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, dma_req, dma_we, dma_addr, dma_wdata, dma_be} = v;
  endtask
  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  initial begin
    ex_t g;
    in_t both;
    int n;
    both = '{1'b1, 0, 32'h0, 32'h0, 4'hF, 1'b1, 0, 32'h8, 32'h0, 4'hF};
    vin[0]  = idle();                              vex[0]  = '{0,0,0,4'h0,10'd0,32'h0,        0,32'h0,        0,32'h0,        0};
    vin[1]  = cpu(1, 32'h10, 32'hDEADBEEF, 4'hF);  vex[1]  = '{0,0,1,4'hF,10'd4,32'hDEADBEEF, 0,32'h0,        0,32'h0,        0};
    vin[2]  = cpu(0, 32'h10, 32'h0, 4'hF);         vex[2]  = '{0,0,1,4'h0,10'd4,32'h0,        0,32'h0,        0,32'h0,        0};
    vin[3]  = idle();                              vex[3]  = '{0,0,0,4'h0,10'd0,32'h0,        1,32'hDEADBEEF, 0,32'h0,        0};
    vin[4]  = cpu(1, 32'h10, 32'h00005500, 4'h2);  vex[4]  = '{0,0,1,4'h2,10'd4,32'h00005500, 0,32'hDEADBEEF, 0,32'h0,        0};
    vin[5]  = cpu(0, 32'h10, 32'h0, 4'hF);         vex[5]  = '{0,0,1,4'h0,10'd4,32'h0,        0,32'hDEADBEEF, 0,32'h0,        0};
    vin[6]  = idle();                              vex[6]  = '{0,0,0,4'h0,10'd0,32'h0,        1,32'hDEAD55EF, 0,32'h0,        0};
    vin[7]  = dma(0, 32'h20, 32'h0, 4'hF);         vex[7]  = '{0,1,1,4'h0,10'd8,32'h0,        0,32'hDEAD55EF, 0,32'h0,        0};
    vin[8]  = cpu(0, 32'h24, 32'h0, 4'hF);         vex[8]  = '{0,0,1,4'h0,10'd9,32'h0,        0,32'hDEAD55EF, 1,32'hA0000008, 0};
    vin[9]  = idle();                              vex[9]  = '{0,0,0,4'h0,10'd0,32'h0,        1,32'hA0000009, 0,32'hA0000008, 0};
    vin[10] = dma(1, 32'h1004, 32'h12345678, 4'hF); vex[10] = '{0,1,1,4'hF,10'd1,32'h12345678, 0,32'hA0000009, 0,32'hA0000008, 0};
    vin[11] = dma(0, 32'h4, 32'h0, 4'hF);          vex[11] = '{0,1,1,4'h0,10'd1,32'h0,        0,32'hA0000009, 0,32'hA0000008, 1};
    vin[12] = idle();                              vex[12] = '{0,0,0,4'h0,10'd0,32'h0,        0,32'hA0000009, 1,32'h12345678, 1};
    vin[13] = both;                                vex[13] = '{0,0,1,4'h0,10'd0,32'h0,        0,32'hA0000009, 0,32'h12345678, 1};
    for (int i = 14; i < 17; i++) begin
      vin[i] = both;                               vex[i]  = '{0,0,1,4'h0,10'd0,32'h0,        1,32'hA0000000, 0,32'h12345678, 1};
    end
    vin[17] = both;                                vex[17] = '{1,1,1,4'h0,10'd2,32'h0,        1,32'hA0000000, 0,32'h12345678, 1};
    vin[18] = both;                                vex[18] = '{0,0,1,4'h0,10'd0,32'h0,        0,32'hA0000000, 1,32'hA0000002, 1};
    vin[19] = idle();                              vex[19] = '{0,0,0,4'h0,10'd0,32'h0,        1,32'hA0000000, 0,32'hA0000002, 1};
    drive(idle());
    repeat (3) @(posedge clk);
    #1 check("reset_state", {cpu_rvalid, dma_rvalid, addr_err, mem_en, dma_gnt, cpu_stall, cpu_rdata, dma_rdata == 32'h0}, 64'h1);
    reset = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 drive(vin[i]);
      @(negedge clk);
      g = '{cpu_stall, dma_gnt, mem_en, mem_we, mem_addr, mem_wdata, cpu_rvalid, cpu_rdata, dma_rvalid, dma_rdata, addr_err};
      if (!vex[i].en) begin
        g.ma = '0;
        g.md = '0;
      end
      nvec++;
      if (g !== vex[i]) begin
        nbad++;
        $display("FAIL vec%0d got=%h exp=%h", i, g, vex[i]);
      end
    end
    // Dropping dma_req must restart the starvation count from zero.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 drive(both);
    end
    @(posedge clk);
    #1 drive(cpu(0, 32'h0, 32'h0, 4'hF));
    n = 0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      @(posedge clk);
      #1 drive(both);
      @(negedge clk);
      if (dma_gnt) n = i;
    end
    check("wait_clear_gnt_cycle", 64'(n), 64'd5);
    check("forced_slot_stall", {63'h0, cpu_stall}, 64'h1);
    // Asynchronous reset right after an accepted read suppresses its return.
    @(posedge clk);
    #1 drive(cpu(0, 32'h24, 32'h0, 4'hF));
    @(posedge clk);
    #1 reset = 1;
    #1 check("async_reset_outs", {cpu_rvalid, dma_rvalid, addr_err, mem_en, mem_we, dma_gnt, cpu_stall}, {54'h0, 10'b0000000001});
    check("async_reset_rdata", {cpu_rdata, dma_rdata}, 64'h0);
    @(posedge clk);
    #1 reset = 0;
    drive(idle());
    @(negedge clk);
    check("post_reset_quiet", {cpu_rvalid, dma_rvalid, addr_err, mem_en}, 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Arbitrates the single-port data RAM between two requesters: the CPU MEM stage (port C) and a DMA/debug master (port D).
- Sits between the MEM pipeline stage and the word-addressed data RAM. The RAM has 1-cycle read latency.
- Fixed priority goes to the CPU, with a starvation guard so the DMA port always progresses.
- Produces the CPU stall signal and steers read data back to the correct requester.

Parameters:
- ADDR_W, 10, word-address width of the RAM (RAM depth = 2^ADDR_W words).
- MAX_WAIT, 4, number of consecutive cycles the DMA may be denied before it is forced a slot (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request (MEM stage holds it stable while cpu_stall=1).
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU write data.
- cpu_be  in  4  CPU byte enables (bit i = byte lane i).
- cpu_stall  out  1  CPU request not accepted this cycle; pipeline must freeze.
- cpu_rvalid  out  1  cpu_rdata valid (one cycle after the accepted CPU read).
- cpu_rdata  out  32  CPU read data.
- dma_req  in  1  DMA access request (held until dma_gnt).
- dma_we  in  1  DMA write enable.
- dma_addr  in  32  DMA byte address.
- dma_wdata  in  32  DMA write data.
- dma_be  in  4  DMA byte enables.
- dma_gnt  out  1  DMA request accepted this cycle.
- dma_rvalid  out  1  dma_rdata valid.
- dma_rdata  out  32  DMA read data.
- addr_err  out  1  sticky flag: an accepted access had addr[31:ADDR_W+2] != 0.
- mem_en  out  1  RAM access strobe.
- mem_we  out  4  RAM per-byte write enables.
- mem_addr  out  ADDR_W  RAM word address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset values (asynchronous):
  - All registered outputs are 0: cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata, addr_err.
  - Internal state: wait_cnt=0, rd_owner=NONE.
  - Combinational outputs during reset: mem_en=0, mem_we=0, dma_gnt=0, cpu_stall=cpu_req.
- Arbitration (combinational, per cycle):
  - force_d = dma_req && (wait_cnt == MAX_WAIT).
  - If force_d: winner is D.
  - Else if cpu_req: winner is C.
  - Else if dma_req: winner is D.
  - Else: no winner.
- Outputs from the winner:
  - cpu_stall = cpu_req && winner != C.
  - dma_gnt = (winner == D).
  - mem_en = 1 whenever there is a winner.
  - mem_addr = winner addr[ADDR_W+1:2].
  - mem_wdata = winner wdata.
  - mem_we = winner we ? winner be : 4'b0000.
  - Byte-lane alignment of wdata/be is the requester's job; this block passes them through.
- Starvation counter wait_cnt (4 bits, registered):
  - Increments when dma_req && winner != D, saturating at MAX_WAIT.
  - Clears to 0 when dma_gnt=1 or dma_req=0.
- Read return (registered):
  - rd_owner <= winner if the winner did a read; otherwise NONE.
  - Next cycle, the owner's rvalid=1 and its rdata = mem_rdata, captured combinationally from the RAM output.
  - The other port's rvalid=0 and its rdata holds its last value.
  - Writes produce no rvalid.
- Back-to-back accesses: one access per cycle, zero bubbles.
  - A read return and a new access overlap legally, since the RAM output is pipelined.
- addr_err:
  - Set on any accepted access (mem_en=1) whose upper address bits are nonzero.
  - The access still proceeds, with the address truncated to ADDR_W bits.
  - Cleared only by reset.
- Simultaneous requests without force_d: the CPU wins, the DMA is held, and wait_cnt increments.
- Reset mid-operation: a pending rvalid is dropped, and wait_cnt and rd_owner are cleared immediately.
- The block contains no RAM state itself; write visibility is the RAM's responsibility (a read the cycle after a write to the same word returns the new data).

Test Plan:
- CPU only: cpu_req=1, we=1, addr=0x10, wdata=0xDEADBEEF, be=F, then a read at 0x10 -> mem_we=F, mem_addr=4; next cycle after the read, cpu_rvalid=1 and cpu_rdata=0xDEADBEEF; cpu_stall=0 throughout.
- Contention: cpu_req and dma_req both held continuously, MAX_WAIT=4 -> CPU wins 4 cycles (cpu_stall=0), 5th cycle dma_gnt=1 and cpu_stall=1, then wait_cnt=0 and the CPU resumes.
- Read steering: DMA read at 0x20 in cycle n, CPU read at 0x24 in cycle n+1 -> dma_rvalid at n+1 with word 8, cpu_rvalid at n+2 with word 9; no cross-valids.
- Byte write: cpu_be=4'b0010, we=1 -> mem_we=4'b0010; a subsequent read shows only lane 1 changed.
- addr_err: dma_addr=0x0000_1004 with ADDR_W=10 -> access to word 1, addr_err=1, and it stays set until reset.
- Async reset asserted in the cycle after a read is accepted -> no rvalid emitted, all outputs at reset values before the next clk edge.
